// File: rtl/round_pipe_pkg.sv
// Rounding-mode definitions and the shared round-up decision for the FP datapath.
// Reused by fp_add as well as round_pipe.
package round_defs;

    typedef logic [2:0] round_mode_t;

    localparam round_mode_t IEEE_NEAR = 3'd0;
    localparam round_mode_t IEEE_ZERO = 3'd1;
    localparam round_mode_t IEEE_PINF = 3'd2;
    localparam round_mode_t IEEE_NINF = 3'd3;
    localparam round_mode_t NEAR_UP   = 3'd4;
    localparam round_mode_t AWAY_ZERO = 3'd5;

    // Round-up decision. Unassigned codes fall back to round-to-nearest-even.
    function automatic logic round_inc(
        input round_mode_t mode,
        input logic        sign,
        input logic        guard,
        input logic        sticky,
        input logic        lsb
    );
        logic inc_s;
        inc_s = 1'b0;
        case (mode)
            IEEE_NEAR: inc_s = guard & (sticky | lsb);
            IEEE_ZERO: inc_s = 1'b0;
            IEEE_PINF: inc_s = ~sign & (guard | sticky);
            IEEE_NINF: inc_s = sign & (guard | sticky);
            NEAR_UP:   inc_s = guard;
            AWAY_ZERO: inc_s = guard | sticky;
            default:   inc_s = guard & (sticky | lsb);
        endcase
        return inc_s;
    endfunction

endpackage

// File: rtl/round_stage_reg.sv
// Generic valid/ready pipeline register: accepts when empty or when the next stage
// drains it this cycle, so a full pipe still moves one item per clock.
module round_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [W-1:0] down_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign up_ready   = ~valid_r | down_ready;
    assign down_valid = valid_r;
    assign down_data  = data_r;

    // Stage occupancy and payload; payload only changes on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (up_ready) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage rounding unit: S1 decides the increment, S2 adds, renormalises and bumps
// the exponent. Define ROUND_STATS_EN to add saturating output-side statistics counters.
module round_pipe
    import round_defs::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 10,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              guard,
    input  logic              sticky,
    input  logic              sign,
    input  logic [2:0]        round,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              inexact,
    output logic              exp_ovf,
    output logic [TAG_W-1:0]  tag_out
`ifdef ROUND_STATS_EN
    ,
    output logic [31:0]       stat_ops,
    output logic [31:0]       stat_inexact,
    output logic [31:0]       stat_carry
`endif
);

    localparam int S1_W = MANT_W + EXP_W + TAG_W + 2;
`ifdef ROUND_STATS_EN
    localparam int S2_W = MANT_W + EXP_W + TAG_W + 3;
`else
    localparam int S2_W = MANT_W + EXP_W + TAG_W + 2;
`endif

    logic              inc_s;
    logic [S1_W-1:0]   s1_d_s;
    logic [S1_W-1:0]   s1_q_s;
    logic              s1_valid_s;
    logic              s2_ready_s;
    logic [MANT_W-1:0] s1_mant_s;
    logic [EXP_W-1:0]  s1_exp_s;
    logic [TAG_W-1:0]  s1_tag_s;
    logic              s1_inc_s;
    logic              s1_inexact_s;
    logic [MANT_W:0]   sum_s;
    logic              carry_s;
    logic [MANT_W-1:0] mant_rnd_s;
    logic [EXP_W-1:0]  exp_rnd_s;
    logic              ovf_s;
    logic [S2_W-1:0]   s2_d_s;
    logic [S2_W-1:0]   s2_q_s;

    assign inc_s  = round_inc(round_mode_t'(round), sign, guard, sticky, mant_in[0]);
    assign s1_d_s = {mant_in, exp_in, tag_in, inc_s, guard | sticky};

    round_stage_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (in_valid),
        .up_ready   (in_ready),
        .up_data    (s1_d_s),
        .down_valid (s1_valid_s),
        .down_ready (s2_ready_s),
        .down_data  (s1_q_s)
    );

    assign {s1_mant_s, s1_exp_s, s1_tag_s, s1_inc_s, s1_inexact_s} = s1_q_s;

    // Increment and renormalise: a carry out leaves 1000..0 and bumps the exponent.
    always_comb begin
        sum_s      = {1'b0, s1_mant_s} + {{MANT_W{1'b0}}, s1_inc_s};
        carry_s    = sum_s[MANT_W];
        mant_rnd_s = sum_s[MANT_W-1:0];
        exp_rnd_s  = s1_exp_s;
        if (carry_s) begin
            mant_rnd_s = sum_s[MANT_W:1];
            exp_rnd_s  = s1_exp_s + {{(EXP_W-1){1'b0}}, 1'b1};
        end else begin
            mant_rnd_s = sum_s[MANT_W-1:0];
            exp_rnd_s  = s1_exp_s;
        end
    end

    assign ovf_s = carry_s & (&s1_exp_s);

`ifdef ROUND_STATS_EN
    logic s2_carry_s;
    assign s2_d_s = {mant_rnd_s, exp_rnd_s, s1_tag_s, s1_inexact_s, ovf_s, carry_s};
`else
    assign s2_d_s = {mant_rnd_s, exp_rnd_s, s1_tag_s, s1_inexact_s, ovf_s};
`endif

    round_stage_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (s1_valid_s),
        .up_ready   (s2_ready_s),
        .up_data    (s2_d_s),
        .down_valid (out_valid),
        .down_ready (out_ready),
        .down_data  (s2_q_s)
    );

`ifdef ROUND_STATS_EN
    assign {mant_out, exp_out, tag_out, inexact, exp_ovf, s2_carry_s} = s2_q_s;

    logic        out_hs_s;
    logic [31:0] ops_r;
    logic [31:0] inexact_r;
    logic [31:0] carry_r;

    assign out_hs_s     = out_valid & out_ready;
    assign stat_ops     = ops_r;
    assign stat_inexact = inexact_r;
    assign stat_carry   = carry_r;

    // Saturating counters sampled on each output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_r     <= 32'd0;
            inexact_r <= 32'd0;
            carry_r   <= 32'd0;
        end else if (out_hs_s) begin
            if (ops_r != 32'hFFFF_FFFF) begin
                ops_r <= ops_r + 32'd1;
            end
            if (inexact && (inexact_r != 32'hFFFF_FFFF)) begin
                inexact_r <= inexact_r + 32'd1;
            end
            if (s2_carry_s && (carry_r != 32'hFFFF_FFFF)) begin
                carry_r <= carry_r + 32'd1;
            end
        end
    end
`else
    assign {mant_out, exp_out, tag_out, inexact, exp_ovf} = s2_q_s;
`endif

endmodule

// File: tb/tb_round_pipe.sv
// Directed self-checking bench for round_pipe (default widths 24/10/4).
// Stats checks are compiled in when ROUND_STATS_EN is defined.
module tb_round_pipe;
    import round_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] mant_in = 24'd0;
    logic [9:0]  exp_in = 10'd0;
    logic        guard = 1'b0;
    logic        sticky = 1'b0;
    logic        sign = 1'b0;
    logic [2:0]  round = 3'd0;
    logic [3:0]  tag_in = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] mant_out;
    logic [9:0]  exp_out;
    logic        inexact;
    logic        exp_ovf;
    logic [3:0]  tag_out;
`ifdef ROUND_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_inexact;
    logic [31:0] stat_carry;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    round_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .guard     (guard),
        .sticky    (sticky),
        .sign      (sign),
        .round     (round),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .inexact   (inexact),
        .exp_ovf   (exp_ovf),
        .tag_out   (tag_out)
`ifdef ROUND_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_inexact (stat_inexact),
        .stat_carry   (stat_carry)
`endif
    );

    typedef struct packed {
        logic [2:0]  mode;
        logic        sgn;
        logic [23:0] m;
        logic [9:0]  e;
        logic        g;
        logic        s;
        logic [23:0] xm;
        logic [9:0]  xe;
        logic        xi;
        logic        xo;
    } vec_t;

    vec_t vecs [0:14];

    // Single operation through an empty pipe with out_ready held high.
    task automatic run_op(input logic [2:0] mode, input logic sgn, input logic [23:0] m,
                          input logic [9:0] e, input logic g, input logic s, input logic [3:0] t,
                          output logic [23:0] om, output logic [9:0] oe, output logic oi,
                          output logic oo, output logic [3:0] ot, output int lat);
        @(negedge clk);
        in_valid = 1'b1; round = mode; sign = sgn; mant_in = m; exp_in = e;
        guard = g; sticky = s; tag_in = t; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1; om = 24'd0; oe = 10'd0; oi = 1'b0; oo = 1'b0; ot = 4'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c; om = mant_out; oe = exp_out; oi = inexact; oo = exp_ovf; ot = tag_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if ({mant_out, exp_out, inexact, exp_ovf, tag_out} !== 40'd0) begin
            n_err++; $display("FAIL reset_outputs got %h/%h/%b/%b/%h want all 0", mant_out, exp_out, inexact, exp_ovf, tag_out);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef ROUND_STATS_EN
        n_cmp++; if ({stat_ops, stat_inexact, stat_carry} !== 96'd0) begin
            n_err++; $display("FAIL reset_stats got %0d/%0d/%0d want 0", stat_ops, stat_inexact, stat_carry);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_modes();
        logic [23:0] om; logic [9:0] oe; logic oi, oo; logic [3:0] ot; int lat;
        vecs[0]  = {IEEE_NEAR, 1'b0, 24'h800001, 10'h050, 1'b1, 1'b0, 24'h800002, 10'h050, 1'b1, 1'b0};
        vecs[1]  = {IEEE_NEAR, 1'b0, 24'h800000, 10'h050, 1'b1, 1'b0, 24'h800000, 10'h050, 1'b1, 1'b0};
        vecs[2]  = {AWAY_ZERO, 1'b0, 24'hFFFFFF, 10'h07F, 1'b0, 1'b1, 24'h800000, 10'h080, 1'b1, 1'b0};
        vecs[3]  = {AWAY_ZERO, 1'b0, 24'hFFFFFF, 10'h3FF, 1'b1, 1'b0, 24'h800000, 10'h000, 1'b1, 1'b1};
        vecs[4]  = {IEEE_PINF, 1'b1, 24'h800003, 10'h010, 1'b1, 1'b0, 24'h800003, 10'h010, 1'b1, 1'b0};
        vecs[5]  = {IEEE_NINF, 1'b1, 24'h800003, 10'h010, 1'b0, 1'b1, 24'h800004, 10'h010, 1'b1, 1'b0};
        vecs[6]  = {3'd7,      1'b0, 24'h800001, 10'h020, 1'b1, 1'b0, 24'h800002, 10'h020, 1'b1, 1'b0};
        vecs[7]  = {3'd7,      1'b0, 24'h800000, 10'h020, 1'b1, 1'b0, 24'h800000, 10'h020, 1'b1, 1'b0};
        vecs[8]  = {IEEE_ZERO, 1'b0, 24'hFFFFFF, 10'h3FF, 1'b1, 1'b1, 24'hFFFFFF, 10'h3FF, 1'b1, 1'b0};
        vecs[9]  = {NEAR_UP,   1'b0, 24'h800000, 10'h001, 1'b1, 1'b0, 24'h800001, 10'h001, 1'b1, 1'b0};
        vecs[10] = {IEEE_NEAR, 1'b0, 24'hABCDEF, 10'h123, 1'b0, 1'b0, 24'hABCDEF, 10'h123, 1'b0, 1'b0};
        vecs[11] = {IEEE_PINF, 1'b0, 24'h800010, 10'h002, 1'b0, 1'b1, 24'h800011, 10'h002, 1'b1, 1'b0};
        vecs[12] = {IEEE_NINF, 1'b0, 24'h800010, 10'h002, 1'b1, 1'b1, 24'h800010, 10'h002, 1'b1, 1'b0};
        vecs[13] = {3'd6,      1'b0, 24'h800003, 10'h004, 1'b1, 1'b0, 24'h800004, 10'h004, 1'b1, 1'b0};
        vecs[14] = {IEEE_NEAR, 1'b0, 24'hFFFFFF, 10'h100, 1'b1, 1'b1, 24'h800000, 10'h101, 1'b1, 1'b0};
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].mode, vecs[i].sgn, vecs[i].m, vecs[i].e, vecs[i].g, vecs[i].s, 4'(i),
                   om, oe, oi, oo, ot, lat);
            n_cmp++; if (lat != 2) begin n_err++; $display("FAIL v%0d latency got %0d want 2", i, lat); end
            n_cmp++; if (om !== vecs[i].xm) begin n_err++; $display("FAIL v%0d mant_out got %h want %h", i, om, vecs[i].xm); end
            n_cmp++; if (oe !== vecs[i].xe) begin n_err++; $display("FAIL v%0d exp_out got %h want %h", i, oe, vecs[i].xe); end
            n_cmp++; if (oi !== vecs[i].xi) begin n_err++; $display("FAIL v%0d inexact got %b want %b", i, oi, vecs[i].xi); end
            n_cmp++; if (oo !== vecs[i].xo) begin n_err++; $display("FAIL v%0d exp_ovf got %b want %b", i, oo, vecs[i].xo); end
            n_cmp++; if (ot !== 4'(i)) begin n_err++; $display("FAIL v%0d tag_out got %h want %h", i, ot, 4'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcvd = 0, c = 0;
        logic prev_stall = 1'b0, in_hs, out_hs;
        logic [23:0] prev_m = 24'd0, xm;
        logic [3:0]  prev_t = 4'd0;
        while (rcvd < 8 && c < 100) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || mant_out !== prev_m || tag_out !== prev_t) begin
                    n_err++; $display("FAIL b2b_stall_stable got %b/%h/%h want 1/%h/%h", out_valid, mant_out, tag_out, prev_m, prev_t);
                end
            end
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (sent < 8) begin
                in_valid = 1'b1; round = NEAR_UP; sign = 1'b0; guard = 1'b1; sticky = 1'b0;
                mant_in = 24'h800000 + 24'(sent); exp_in = 10'(sent); tag_in = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            in_hs  = in_valid & in_ready;
            out_hs = out_valid & out_ready;
            if (out_hs) begin
                xm = 24'h800001 + 24'(rcvd);
                n_cmp++; if (tag_out !== 4'(rcvd)) begin n_err++; $display("FAIL b2b_tag got %h want %h", tag_out, 4'(rcvd)); end
                n_cmp++; if (mant_out !== xm) begin n_err++; $display("FAIL b2b_mant got %h want %h", mant_out, xm); end
                n_cmp++; if (exp_out !== 10'(rcvd)) begin n_err++; $display("FAIL b2b_exp got %h want %h", exp_out, 10'(rcvd)); end
                rcvd++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_m = mant_out;
            prev_t = tag_out;
            @(posedge clk);
            if (in_hs) sent++;
            c++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (rcvd != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", rcvd); end
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_extra got %b want 0", out_valid); end
    endtask

`ifdef ROUND_STATS_EN
    task automatic test_stats();
        n_cmp++; if (stat_ops !== 32'd23) begin n_err++; $display("FAIL stat_ops got %0d want 23", stat_ops); end
        n_cmp++; if (stat_inexact !== 32'd22) begin n_err++; $display("FAIL stat_inexact got %0d want 22", stat_inexact); end
        n_cmp++; if (stat_carry !== 32'd3) begin n_err++; $display("FAIL stat_carry got %0d want 3", stat_carry); end
    endtask
`endif

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; round = IEEE_NEAR; mant_in = 24'h812345;
        exp_in = 10'h011; guard = 1'b0; sticky = 1'b0; sign = 1'b0; tag_in = 4'h9;
        @(posedge clk);
        @(negedge clk);
        mant_in = 24'h854321; tag_in = 4'hA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || tag_out !== 4'h9) begin n_err++; $display("FAIL full_out got %b/%h want 1/9", out_valid, tag_out); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        n_cmp++; if (mant_out !== 24'd0 || tag_out !== 4'd0) begin n_err++; $display("FAIL flush_outputs got %h/%h want 0/0", mant_out, tag_out); end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
`ifdef ROUND_STATS_EN
        n_cmp++; if ({stat_ops, stat_inexact, stat_carry} !== 96'd0) begin
            n_err++; $display("FAIL flush_stats got %0d/%0d/%0d want 0", stat_ops, stat_inexact, stat_carry);
        end
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_discarded got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
`ifdef ROUND_STATS_EN
        test_stats();
`endif
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/round_pipe.md
Name: round_pipe

Overview:
- Parametrised, pipelined rounding unit for the FP datapath; successor of the single-cycle multiplier rounding stage.
- Takes a normalised mantissa plus guard/sticky, sign, exponent and rounding mode, and applies one of six rounding modes.
- Renormalises on carry-out and increments the exponent itself, instead of deferring that step to the caller.
- Sits between the fp_mult/fp_add normalisers and result packing; uses a valid/ready handshake with full backpressure.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 10, exponent field width (unsigned, biased).
- TAG_W, 4, opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- mant_in  in  MANT_W  normalised mantissa (MSB = hidden one).
- exp_in  in  EXP_W  exponent before rounding.
- guard  in  1  first discarded bit.
- sticky  in  1  OR of the remaining discarded bits.
- sign  in  1  result sign.
- round  in  3  rounding mode, encoded per round_defs.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- mant_out  out  MANT_W  rounded, renormalised mantissa.
- exp_out  out  EXP_W  adjusted exponent.
- inexact  out  1  guard OR sticky.
- exp_ovf  out  1  exponent wrapped on carry increment.
- tag_out  out  TAG_W  tag of the result.

Behaviour:
- Reset: all valid bits and all outputs are 0.
- Two-stage pipeline; latency is exactly 2 cycles from input handshake to out_valid when out_ready is held 1.
- Throughput is 1 operation per cycle.
- S1 captures the inputs and computes inc (the round-up decision) and inexact = guard | sticky.
- inc per mode:
  - IEEE_NEAR: guard & (sticky | mant[0]).
  - IEEE_ZERO: 0.
  - IEEE_PINF: ~sign & (guard | sticky).
  - IEEE_NINF: sign & (guard | sticky).
  - NEAR_UP: guard.
  - AWAY_ZERO: guard | sticky.
  - Undefined codes (6, 7): treated as IEEE_NEAR.
- S2 computes sum = {1'b0, mant} + inc in MANT_W+1 bits.
  - If sum[MANT_W] = 1: mant_out = sum[MANT_W:1], i.e. 1000..0, and exp_out = exp + 1.
  - Otherwise: mant_out = sum[MANT_W-1:0] and exp_out = exp.
- exp_ovf = 1 only when a carry occurs with exp = all-ones; exp_out then wraps to 0.
- tag, inexact and sign decisions travel with the data through both stages.
- Handshake:
  - A transfer occurs on valid & ready at either port.
  - Each stage advances when it is empty or the stage after it advances.
  - in_ready = ~s1_valid | s1_advance.
  - out_valid and all outputs hold stable while out_valid & ~out_ready.
- Simultaneous input accept and output drain with both stages full: no bubble, no loss.
- in_valid while in_ready = 0: the input is ignored; the source must hold it.
- rst asserted mid-operation: both stages are flushed immediately; in-flight operations are discarded.
- No combinational path from in_valid to out_valid. A combinational path from out_ready to in_ready is allowed.

Optional Feature:
- Macro: ROUND_STATS_EN.
- When defined, adds three output ports:
  - stat_ops  out  32  operations output.
  - stat_inexact  out  32  inexact results.
  - stat_carry  out  32  carry renormalisations.
- Each counter increments on an output handshake when its condition holds.
- Counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package round_defs holds:
  - Rounding-mode constants: IEEE_NEAR=0, IEEE_ZERO=1, IEEE_PINF=2, IEEE_NINF=3, NEAR_UP=4, AWAY_ZERO=5.
  - A round_mode_t 3-bit typedef.
- The combinational inc-decision function lives in the package so fp_add can reuse it.
- One sub-module: round_stage_reg, a generic valid/ready pipeline register instantiated once per stage.

Test Plan:
- IEEE_NEAR, mant=0x800001, g=1, s=0 -> mant_out=0x800002, exp unchanged, inexact=1.
- IEEE_NEAR, mant=0x800000, g=1, s=0 (tie, even) -> mant_out=0x800000, inexact=1.
- AWAY_ZERO, mant=0xFFFFFF, exp=0x07F, g=0, s=1 -> mant_out=0x800000, exp_out=0x080, exp_ovf=0.
- Carry at exp=0x3FF -> exp_out=0x000, exp_ovf=1. IEEE_PINF sign=1 g=1 -> no increment. IEEE_NINF sign=1 s=1 -> increment. round=7 -> behaves as IEEE_NEAR.
- Stream of 8 back-to-back ops with tags 0-7 and out_ready toggling 1,0,0,1,... -> all 8 results in order, outputs stable during stalls, no drops.
- rst asserted with both stages full -> out_valid=0 the same cycle, in_ready=1 after release. With ROUND_STATS_EN, the counters read 0.
